// File: rtl/frame_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// frame_pkg : shared frame layout and state encoding for the serial link
// Revision  : 1.0
// ----------------------------------------------------------------------------
package frame_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARM   = 2'd1,
    DATA  = 2'd2,
    GUARD = 2'd3
  } state_e;

  localparam int FRAME_DATA_WIDTH = 8;
  localparam int FRAME_SIZE       = FRAME_DATA_WIDTH + 3;

  localparam logic START_BIT  = 1'b0;
  localparam logic STOP_BIT   = 1'b1;
  localparam logic IDLE_LEVEL = 1'b1;

  // Field positions within a frame; the receive side decodes with the same map.
  localparam int START_POS  = 0;
  localparam int DATA_LSB   = 1;
  localparam int PARITY_POS = FRAME_DATA_WIDTH + 1;
  localparam int STOP_POS   = FRAME_DATA_WIDTH + 2;

endpackage
`default_nettype wire

// File: rtl/frame_transmitter_parity_gen.sv
`default_nettype none
// ----------------------------------------------------------------------------
// parity_gen : combinational parity over a data word (odd or even)
// Revision   : 1.0
// ----------------------------------------------------------------------------
module parity_gen #(
  parameter int DATA_WIDTH = 8,
  parameter int ODD_PARITY = 1
) (
  input  logic [DATA_WIDTH-1:0] data_i,
  output logic                  parity_o
);

  assign parity_o = (^data_i) ^ (ODD_PARITY != 0);

endmodule
`default_nettype wire

// File: rtl/frame_transmitter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// frame_transmitter : serializes one word as start, data LSB first, parity, stop
// Revision          : 1.0
// ----------------------------------------------------------------------------
module frame_transmitter
  import frame_pkg::*;
#(
  parameter int DATA_WIDTH  = FRAME_DATA_WIDTH,
  parameter int ODD_PARITY  = 1,
  parameter int GUARD_TICKS = 1
) (
  input  logic                  control_clock,
  input  logic                  reset_n,
  input  logic                  bit_tick,
  input  logic                  send_request,
  input  logic [DATA_WIDTH-1:0] parallel_data,
  output logic                  serial_data,
  output logic                  ready,
  output logic                  busy,
  output logic                  send_done
);

  localparam int CW = $clog2(DATA_WIDTH + 3);
  localparam int GW = (GUARD_TICKS > 0) ? $clog2(GUARD_TICKS + 1) : 1;

  localparam logic [CW-1:0] C_PARITY_CNT = CW'(DATA_WIDTH);
  localparam logic [CW-1:0] C_STOP_CNT   = CW'(DATA_WIDTH + 1);
  localparam logic [CW-1:0] C_END_CNT    = CW'(DATA_WIDTH + 2);
  localparam logic [GW-1:0] C_GUARD_LAST = GW'(GUARD_TICKS - 1);

  state_e                state_q;
  logic [DATA_WIDTH-1:0] tx_shift_q;
  logic                  parity_q;
  logic [CW-1:0]         bit_cnt_q;
  logic [GW-1:0]         guard_cnt_q;
  logic                  serial_q;
  logic                  ready_q;
  logic                  busy_q;
  logic                  done_q;
  logic                  parity_d;

  parity_gen #(
    .DATA_WIDTH (DATA_WIDTH),
    .ODD_PARITY (ODD_PARITY)
  ) u_parity_gen (
    .data_i   (parallel_data),
    .parity_o (parity_d)
  );

  always_ff @(posedge control_clock) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      tx_shift_q  <= '0;
      parity_q    <= 1'b0;
      bit_cnt_q   <= '0;
      guard_cnt_q <= '0;
      serial_q    <= IDLE_LEVEL;
      ready_q     <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          // ready rises one cycle after send_done, so the done cycle never accepts
          serial_q <= IDLE_LEVEL;
          ready_q  <= 1'b1;
          if (ready_q && send_request) begin
            tx_shift_q <= parallel_data;
            parity_q   <= parity_d;
            ready_q    <= 1'b0;
            busy_q     <= 1'b1;
            state_q    <= ARM;
          end
        end
        ARM: begin
          if (bit_tick) begin
            serial_q  <= START_BIT;
            bit_cnt_q <= '0;
            state_q   <= DATA;
          end
        end
        DATA: begin
          if (bit_tick) begin
            if (bit_cnt_q < C_PARITY_CNT) begin
              serial_q   <= tx_shift_q[0];
              tx_shift_q <= tx_shift_q >> 1;
            end else if (bit_cnt_q == C_PARITY_CNT) begin
              serial_q <= parity_q;
            end else if (bit_cnt_q == C_STOP_CNT) begin
              serial_q <= STOP_BIT;
            end else begin
              // this tick closes the stop bit
              serial_q    <= IDLE_LEVEL;
              guard_cnt_q <= '0;
              if (GUARD_TICKS == 0) begin
                done_q  <= 1'b1;
                busy_q  <= 1'b0;
                state_q <= IDLE;
              end else begin
                state_q <= GUARD;
              end
            end
            if (bit_cnt_q != C_END_CNT) begin
              bit_cnt_q <= bit_cnt_q + 1'b1;
            end
          end
        end
        GUARD: begin
          if (bit_tick) begin
            if (guard_cnt_q == C_GUARD_LAST) begin
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
              state_q <= IDLE;
            end else begin
              guard_cnt_q <= guard_cnt_q + 1'b1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign serial_data = serial_q;
  assign ready       = ready_q;
  assign busy        = busy_q;
  assign send_done   = done_q;

endmodule
`default_nettype wire

// File: tb/tb_frame_transmitter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_frame_transmitter : three transmitter variants against a frame-level model
// Revision             : 1.0
// ----------------------------------------------------------------------------
module tb_frame_transmitter;

  localparam int TICK = 8;

  logic       clk;
  logic       rst_n;
  logic       bit_tick;
  logic [7:0] data;
  logic       req [3];
  logic       ser [3];
  logic       rdy [3];
  logic       bsy [3];
  logic       dne [3];

  int checks = 0;
  int errors = 0;
  int tick_div = 0;

  // 0: odd parity, guard 1   1: even parity, guard 1   2: odd parity, guard 0
  frame_transmitter #(.DATA_WIDTH(8), .ODD_PARITY(1), .GUARD_TICKS(1)) u_dut_a (
    .control_clock(clk), .reset_n(rst_n), .bit_tick(bit_tick), .send_request(req[0]),
    .parallel_data(data), .serial_data(ser[0]), .ready(rdy[0]), .busy(bsy[0]), .send_done(dne[0]));
  frame_transmitter #(.DATA_WIDTH(8), .ODD_PARITY(0), .GUARD_TICKS(1)) u_dut_b (
    .control_clock(clk), .reset_n(rst_n), .bit_tick(bit_tick), .send_request(req[1]),
    .parallel_data(data), .serial_data(ser[1]), .ready(rdy[1]), .busy(bsy[1]), .send_done(dne[1]));
  frame_transmitter #(.DATA_WIDTH(8), .ODD_PARITY(1), .GUARD_TICKS(0)) u_dut_c (
    .control_clock(clk), .reset_n(rst_n), .bit_tick(bit_tick), .send_request(req[2]),
    .parallel_data(data), .serial_data(ser[2]), .ready(rdy[2]), .busy(bsy[2]), .send_done(dne[2]));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    bit_tick = 1'b0;
    forever begin
      @(negedge clk);
      tick_div = (tick_div == TICK - 1) ? 0 : tick_div + 1;
      bit_tick = (tick_div == 0);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout required completion");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected line level for each bit position of a frame, from the byte alone.
  function automatic logic [10:0] model_frame(input logic [7:0] d, input bit odd);
    int ones = 0;
    logic [10:0] f;
    for (int i = 0; i < 8; i++) ones += int'(d[i]);
    f[0] = 1'b0;
    for (int i = 0; i < 8; i++) f[1 + i] = d[i];
    f[9]  = odd ? (ones % 2 == 0) : (ones % 2 == 1);
    f[10] = 1'b1;
    return f;
  endfunction

  function automatic string bit_tag(input int pos);
    if (pos == 0)  return "start_bit";
    if (pos <= 8)  return "data_bit";
    if (pos == 9)  return "parity_bit";
    if (pos == 10) return "stop_bit";
    return "guard_idle";
  endfunction

  task automatic run_frame(input int idx, input logic [7:0] d, input bit odd, input int g,
                           input bit hold, input logic [7:0] next_d, input bit inject);
    logic [10:0] f;
    bit          found;
    int          lat;
    int          dn;
    logic        exp_s;
    f  = model_frame(d, odd);
    dn = (11 + g) * TICK;
    @(negedge clk);
    data     = d;
    req[idx] = 1'b1;
    found    = 1'b0;
    for (int i = 0; i < 3 * TICK && !found; i++) begin
      @(posedge clk); #1;
      if (bsy[idx] === 1'b1) found = 1'b1;
    end
    chk("accept_busy", bsy[idx], 1'b1);
    chk("accept_ready", rdy[idx], 1'b0);
    chk("accept_line_idle", ser[idx], 1'b1);
    if (hold) data = next_d;
    else begin
      req[idx] = 1'b0;
      data     = 8'($urandom);
    end
    found = 1'b0;
    lat   = 0;
    for (int i = 1; i <= 2 * TICK && !found; i++) begin
      @(posedge clk); #1;
      if (ser[idx] === 1'b0) begin
        found = 1'b1;
        lat   = i;
      end
    end
    chk("start_latency_ok", (found && lat >= 1 && lat <= TICK), 1'b1);
    chk("done_at_start", dne[idx], 1'b0);
    for (int c = 1; c <= dn + 1; c++) begin
      @(posedge clk); #1;
      if (inject && c == 3 * TICK) begin
        req[idx] = 1'b1;
        data     = 8'hC3;
      end
      if (inject && c == dn - 2) req[idx] = 1'b0;
      exp_s = (c / TICK < 11) ? f[c / TICK] : 1'b1;
      chk(bit_tag(c / TICK), ser[idx], exp_s);
      chk("send_done", dne[idx], (c == dn));
      if (c <= dn) chk("busy", bsy[idx], (c < dn));
      if (c == dn) chk("ready_at_done", rdy[idx], 1'b0);
      if (c == dn + 1) chk("ready_after_done", rdy[idx], 1'b1);
    end
  endtask

  initial begin
    bit ok;
    rst_n  = 1'b0;
    data   = 8'h00;
    for (int i = 0; i < 3; i++) req[i] = 1'b0;

    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) begin
      chk("reset_serial", ser[i], 1'b1);
      chk("reset_ready", rdy[i], 1'b1);
      chk("reset_busy", bsy[i], 1'b0);
      chk("reset_done", dne[i], 1'b0);
    end

    ok = 1'b1;
    repeat (20 * TICK) begin
      @(posedge clk); #1;
      for (int i = 0; i < 3; i++)
        if (ser[i] !== 1'b1 || dne[i] !== 1'b0 || rdy[i] !== 1'b1) ok = 1'b0;
    end
    chk("idle_line_high", ok, 1'b1);

    run_frame(0, 8'h5A, 1'b1, 1, 1'b0, 8'h00, 1'b0);
    run_frame(0, 8'h01, 1'b1, 1, 1'b0, 8'h00, 1'b0);
    run_frame(0, 8'h00, 1'b1, 1, 1'b0, 8'h00, 1'b0);
    run_frame(0, 8'hFF, 1'b1, 1, 1'b0, 8'h00, 1'b0);
    run_frame(1, 8'h01, 1'b0, 1, 1'b0, 8'h00, 1'b0);
    run_frame(0, 8'h5A, 1'b1, 1, 1'b0, 8'h00, 1'b1);

    run_frame(2, 8'h11, 1'b1, 0, 1'b1, 8'h22, 1'b0);
    run_frame(2, 8'h22, 1'b1, 0, 1'b0, 8'h00, 1'b0);

    for (int k = 0; k < 3; k++) begin
      run_frame(0, 8'($urandom), 1'b1, 1, 1'b0, 8'h00, 1'b0);
      run_frame(1, 8'($urandom), 1'b0, 1, 1'b0, 8'h00, 1'b0);
    end

    // Abort a frame during data bit 4, then send a fresh one.
    @(negedge clk);
    data   = 8'h3C;
    req[0] = 1'b1;
    ok     = 1'b0;
    for (int i = 0; i < 3 * TICK && !ok; i++) begin
      @(posedge clk); #1;
      if (bsy[0] === 1'b1) ok = 1'b1;
    end
    req[0] = 1'b0;
    ok     = 1'b0;
    for (int i = 0; i < 2 * TICK && !ok; i++) begin
      @(posedge clk); #1;
      if (ser[0] === 1'b0) ok = 1'b1;
    end
    chk("abort_frame_started", ok, 1'b1);
    repeat (5 * TICK + 3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("abort_serial", ser[0], 1'b1);
    chk("abort_ready", rdy[0], 1'b1);
    chk("abort_busy", bsy[0], 1'b0);
    chk("abort_done", dne[0], 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    ok = 1'b1;
    repeat (14 * TICK) begin
      @(posedge clk); #1;
      if (dne[0] !== 1'b0 || ser[0] !== 1'b1) ok = 1'b0;
    end
    chk("abort_no_done", ok, 1'b1);
    run_frame(0, 8'hA5, 1'b1, 1, 1'b0, 8'h00, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
